// File: rtl/vga_pkg.sv
// Shared VGA definitions: default timing, RGB565 colours, bounce palette,
// and the coordinate value vga_ctrl drives outside the active area.
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  localparam logic [9:0] PIX_INVALID = 10'h3FF;

  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_ORANGE  = 16'hFC00;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  function automatic logic [15:0] palette(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_RED;
      3'd1:    c = RGB_GREEN;
      3'd2:    c = RGB_BLUE;
      3'd3:    c = RGB_YELLOW;
      3'd4:    c = RGB_CYAN;
      3'd5:    c = RGB_MAGENTA;
      3'd6:    c = RGB_ORANGE;
      default: c = RGB_WHITE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One motion axis of the bouncing square: clamped position plus a
// two-state direction FSM. flip pulses in the tick that reverses direction.
module vga_bounce_axis
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [10:0] lim,
  input  logic [10:0] step,
  output logic [9:0]  pos,
  output logic        flip
);

  dir_e        dir_q, dir_d;
  logic [9:0]  pos_q, pos_d;
  logic [10:0] inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_INC;
      pos_q <= '0;
    end else begin
      dir_q <= dir_d;
      pos_q <= pos_d;
    end
  end

  // Both edges clamp rather than overshoot, so pos stays in [0, lim].
  always_comb begin
    dir_d = dir_q;
    pos_d = pos_q;
    flip  = 1'b0;
    inc   = {1'b0, pos_q} + step;
    if (tick) begin
      case (dir_q)
        DIR_INC: begin
          if (inc >= lim) begin
            pos_d = 10'(lim);
            dir_d = DIR_DEC;
            flip  = 1'b1;
          end else begin
            pos_d = 10'(inc);
          end
        end
        default: begin
          if ({1'b0, pos_q} <= step) begin
            pos_d = '0;
            dir_d = DIR_INC;
            flip  = 1'b1;
          end else begin
            pos_d = 10'({1'b0, pos_q} - step);
          end
        end
      endcase
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_bounce_pic.sv
// Bouncing-square picture source feeding vga_ctrl; RGB565 out, 1-cycle latency.
// Optional white frame border when VGA_BOUNCE_BORDER_EN is defined.
module vga_bounce_pic
  import vga_pkg::*;
#(
  parameter int          H_VALID  = H_VALID_DEF,
  parameter int          V_VALID  = V_VALID_DEF,
  parameter int          SIDE     = 32,
  parameter int          STEP     = 4,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pause,
  output logic [15:0] pix_data
);

  localparam logic [10:0] LIM_X  = 11'(H_VALID - SIDE);
  localparam logic [10:0] LIM_Y  = 11'(V_VALID - SIDE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] SIDE_W = 11'(SIDE);
  localparam logic [9:0]  X_LAST = 10'(H_VALID - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_VALID - 1);

  logic        frame_tick, move;
  logic [9:0]  box_x, box_y;
  logic        flip_x, flip_y;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] pix_q, pix_d;
  logic [10:0] x_end, y_end;
  logic        in_box;

  assign frame_tick = (pix_x == X_LAST) && (pix_y == Y_LAST);
  // pause only matters at the tick; elsewhere it is ignored.
  assign move = frame_tick && !pause;

  vga_bounce_axis u_axis_x (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .tick  (move),
    .lim   (LIM_X),
    .step  (STEP_W),
    .pos   (box_x),
    .flip  (flip_x)
  );

  vga_bounce_axis u_axis_y (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .tick  (move),
    .lim   (LIM_Y),
    .step  (STEP_W),
    .pos   (box_y),
    .flip  (flip_y)
  );

  // A corner hit flips both axes but counts as a single bounce.
  always_comb begin
    idx_d = idx_q;
    if (flip_x || flip_y) idx_d = idx_q + 3'd1;
  end

  always_comb begin
    x_end  = {1'b0, box_x} + SIDE_W;
    y_end  = {1'b0, box_y} + SIDE_W;
    in_box = (pix_x >= box_x) && ({1'b0, pix_x} < x_end) &&
             (pix_y >= box_y) && ({1'b0, pix_y} < y_end);
    pix_d  = BG_COLOR;
    if (pix_x == PIX_INVALID || pix_y == PIX_INVALID) begin
      pix_d = RGB_BLACK;
    end else if (in_box) begin
      pix_d = palette(idx_q);
    end
`ifdef VGA_BOUNCE_BORDER_EN
    else if (pix_x == '0 || pix_x == X_LAST || pix_y == '0 || pix_y == Y_LAST) begin
      pix_d = RGB_WHITE;
    end
`endif
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q <= '0;
      pix_q <= '0;
    end else begin
      idx_q <= idx_d;
      pix_q <= pix_d;
    end
  end

  assign pix_data = pix_q;

endmodule

// File: tb/tb_vga_bounce_pic.sv
// Bench for vga_bounce_pic: two instances (STEP 4 and STEP 6) against a
// velocity/clamp reference model, probed with random coordinates each frame.
module tb_vga_bounce_pic;

  localparam int HV = 640;
  localparam int VV = 480;
  localparam int SD = 32;
  localparam logic [15:0] PAL [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                                      16'h07FF, 16'hF81F, 16'hFC00, 16'hFFFF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = 10'h3FF;
  logic [9:0]  pix_y = 10'h3FF;
  logic        pause = 1'b0;
  logic [15:0] d0, d1;

  always #5 clk = ~clk;

  vga_bounce_pic u_dut4 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .pause(pause), .pix_data(d0)
  );

  vga_bounce_pic #(.STEP(6), .BG_COLOR(16'h18E3)) u_dut6 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .pause(pause), .pix_data(d1)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: position, signed velocity, colour index per instance.
  int step_m [2] = '{4, 6};
  logic [15:0] bg_m [2] = '{16'h0000, 16'h18E3};
  int bx [2], by [2], vx [2], vy [2], ci [2];
  int corners = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      bx[i] = 0; by[i] = 0; vx[i] = step_m[i]; vy[i] = step_m[i]; ci[i] = 0;
    end
  endfunction

  function automatic void model_tick(input int i);
    int nx, ny;
    bit fx, fy;
    nx = bx[i] + vx[i]; fx = 0;
    if (nx <= 0) begin nx = 0; fx = 1; end
    else if (nx >= HV - SD) begin nx = HV - SD; fx = 1; end
    ny = by[i] + vy[i]; fy = 0;
    if (ny <= 0) begin ny = 0; fy = 1; end
    else if (ny >= VV - SD) begin ny = VV - SD; fy = 1; end
    if (fx) vx[i] = -vx[i];
    if (fy) vy[i] = -vy[i];
    if (fx || fy) ci[i] = (ci[i] + 1) % 8;
    if (fx && fy && i == 0) corners++;
    bx[i] = nx; by[i] = ny;
  endfunction

  function automatic logic [15:0] exp_pix(input int i, input int x, input int y);
    if (x == 1023 || y == 1023) return 16'h0000;
    if (x >= bx[i] && x < bx[i] + SD && y >= by[i] && y < by[i] + SD) return PAL[ci[i]];
`ifdef VGA_BOUNCE_BORDER_EN
    if (x == 0 || x == HV - 1 || y == 0 || y == VV - 1) return 16'hFFFF;
`endif
    return bg_m[i];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel-clock: present (x,y), then compare the registered pixel.
  task automatic cyc(input int x, input int y, input logic p);
    logic [15:0] e0, e1;
    bit tk;
    @(negedge clk);
    pix_x = 10'(x); pix_y = 10'(y); pause = p;
    e0 = exp_pix(0, x, y);
    e1 = exp_pix(1, x, y);
    tk = (x == HV - 1) && (y == VV - 1);
    @(posedge clk); #1;
    if (tk && !p) begin model_tick(0); model_tick(1); end
    check("pix_s4", d0, e0);
    check("pix_s6", d1, e1);
  endtask

  function automatic int clipv(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Probes around both squares and elsewhere, then a frame tick.
  task automatic frame(input logic tick_pause);
    int x, y;
    cyc(bx[0], by[0], 1'($urandom_range(0, 1)));
    cyc(bx[0] + SD - 1, by[0] + SD - 1, 1'($urandom_range(0, 1)));
    x = clipv(bx[0] + int'($urandom_range(0, SD + 3)) - 2, HV - 1);
    y = clipv(by[0] + int'($urandom_range(0, SD + 3)) - 2, VV - 1);
    if (x == HV - 1 && y == VV - 1) y = VV - 2;
    cyc(x, y, 1'($urandom_range(0, 1)));
    x = clipv(bx[1] + int'($urandom_range(0, SD + 3)) - 2, HV - 1);
    y = clipv(by[1] + int'($urandom_range(0, SD + 3)) - 2, VV - 1);
    if (x == HV - 1 && y == VV - 1) y = VV - 2;
    cyc(x, y, 1'($urandom_range(0, 1)));
    x = int'($urandom_range(0, HV - 1));
    y = int'($urandom_range(0, VV - 2));
    if ($urandom_range(0, 7) == 0) x = 1023;
    else if ($urandom_range(0, 7) == 0) y = 1023;
    cyc(x, y, 1'($urandom_range(0, 1)));
    cyc(HV - 1, VV - 1, tick_pause);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_s4", d0, 16'h0000);
    check("rst_s6", d1, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    cyc(0, 0, 1'b0);
    cyc(SD, 0, 1'b0);
    cyc(1023, 10, 1'b0);
    cyc(10, 1023, 1'b0);

    // Uninterrupted motion long enough to cover clamps on both edges,
    // colour wrap and a full corner hit of the STEP-4 square.
    for (int t = 0; t < 2135; t++) frame(1'b0);
    if (corners == 0) $display("note: no corner reached by STEP-4 model");

    for (int t = 0; t < 3; t++) frame(1'b1);
    for (int t = 0; t < 60; t++) frame(1'($urandom_range(0, 3) == 0));

    cyc(0, 200, 1'b0);
    cyc(HV - 1, 100, 1'b0);
    cyc(300, VV - 1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    pix_x = 10'(bx[0]); pix_y = 10'(by[0]);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_s4", d0, 16'h0000);
    check("midrst_s6", d1, 16'h0000);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cyc(0, 0, 1'b0);
    cyc(SD, SD, 1'b0);
    for (int t = 0; t < 5; t++) frame(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
